// File: rtl/ps2_key_event_fifo.sv
// rtl/ps2_key_event_fifo.sv - PS/2 set-2 make/break parser with held-key bitmap and FWFT event FIFO
//
// Purpose:
//    Turns the raw byte stream from PS2_Controller into {ext, brk, code} events.
//    It handles the E0 (extended) and F0 (break) prefixes.
//    It tracks a held-down bitmap for a configurable set of game keys.
//    It queues events in a first-word-fall-through FIFO, so the game FSM sees
//    every keystroke.
//
// Ports:
//    clock         system clock (CLOCK_50)
//    resetn        asynchronous active-low reset
//    rx_data       byte from PS2_Controller received_data
//    rx_valid      one-cycle strobe, received_data_en
//    ev_data       head event {ext, brk, code[7:0]}, meaningful while ev_valid=1
//    ev_valid      FIFO non-empty
//    ev_ready      consumer pops the head when ev_valid & ev_ready
//    count         current FIFO occupancy
//    overflow      sticky, set when an event was dropped on a full FIFO
//    clr_overflow  synchronous clear of overflow (a simultaneous drop wins)
//    key_down      one bit per tracked key, 1 = currently held
//
// Build option:
//    PS2_REPEAT_FILTER_EN - when defined, a non-extended make of a tracked key
//    that is already held is not queued, which suppresses typematic repeats.

module ps2_key_event_fifo #(
   parameter int                    DEPTH     = 8,
   parameter int                    NUM_KEYS  = 4,
   parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {8'h23, 8'h1B, 8'h1C, 8'h1D}
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   output logic [9:0]                 ev_data,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clr_overflow,
   output logic [NUM_KEYS-1:0]        key_down
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t               state;
   state_t               next_state;
   logic [9:0]           mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;

   logic                 is_e0;
   logic                 is_f0;
   logic                 is_ignored;
   logic                 emit;
   logic                 ev_ext;
   logic                 ev_brk;
   logic [NUM_KEYS-1:0]  key_match;
   logic                 repeat_hit;
   logic                 push_req;
   logic                 push_ok;
   logic                 drop;
   logic                 pop;

   assign is_e0 = (rx_data == 8'hE0);
   assign is_f0 = (rx_data == 8'hF0);

   // Keyboard housekeeping replies (BAT, echo, ack, resend, error) carry no key.
   always_comb begin
      is_ignored = 1'b0;
      case (rx_data)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
         default:                                  is_ignored = 1'b0;
      endcase
   end

   always_comb begin
      next_state = state;
      emit       = 1'b0;
      ev_ext     = 1'b0;
      ev_brk     = 1'b0;
      if (rx_valid) begin
         case (state)
            S_IDLE: begin
               if (is_e0)            next_state = S_EXT;
               else if (is_f0)       next_state = S_BRK;
               else if (!is_ignored) emit = 1'b1;
            end
            S_EXT: begin
               if (is_f0) begin
                  next_state = S_EXT_BRK;
               end else if (!is_e0) begin
                  emit       = 1'b1;
                  ev_ext     = 1'b1;
                  next_state = S_IDLE;
               end
            end
            S_BRK: begin
               // A prefix right after F0 is a protocol error: resynchronise in IDLE.
               next_state = S_IDLE;
               if (!is_e0 && !is_f0) begin
                  emit   = 1'b1;
                  ev_brk = 1'b1;
               end
            end
            default: begin
               next_state = S_IDLE;
               if (!is_e0 && !is_f0) begin
                  emit   = 1'b1;
                  ev_ext = 1'b1;
                  ev_brk = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      key_match = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         key_match[i] = (KEY_CODES[8*i +: 8] == rx_data);
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   assign repeat_hit = !ev_ext && !ev_brk && |(key_match & key_down);
`else
   assign repeat_hit = 1'b0;
`endif

   assign push_req = emit && !repeat_hit;
   assign pop      = ev_valid && ev_ready;
   // A full FIFO can still take a push when the head leaves on the same edge.
   assign push_ok  = push_req && ((count < CW'(DEPTH)) || pop);
   assign drop     = push_req && !push_ok;

   assign ev_valid = (count != '0);
   assign ev_data  = mem[rd_ptr];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         key_down <= '0;
      end else begin
         state <= next_state;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
         // Extended codes share code values with tracked keys, so they must not touch the bitmap.
         if (emit && !ev_ext) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
               if (key_match[i]) key_down[i] <= !ev_brk;
            end
         end
      end
   end

   // Storage needs no reset: entries are only read once count marks them valid.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= {ev_ext, ev_brk, rx_data};
   end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb/tb_ps2_key_event_fifo.sv - self-checking bench for ps2_key_event_fifo

module tb_ps2_key_event_fifo;

   localparam int DEPTH = 8;
   localparam logic [31:0] CODES = {8'h23, 8'h1B, 8'h1C, 8'h1D};

   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [9:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [3:0] count;
   logic       overflow;
   logic       clr_overflow;
   logic [3:0] key_down;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   ps2_key_event_fifo #(.DEPTH(DEPTH), .NUM_KEYS(4), .KEY_CODES(CODES)) dut (
      .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
      .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .count(count),
      .overflow(overflow), .clr_overflow(clr_overflow), .key_down(key_down)
   );

   // Reference model: event queue, held-key array, sticky drop flag, pending prefixes.
   logic [9:0] mq [$];
   logic [3:0] m_keys;
   logic       m_ovf;
   bit         m_ext;
   bit         m_brk;

   task automatic model_reset();
      mq.delete();
      m_keys = '0;
      m_ovf  = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
   endtask

   task automatic model_cycle(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      bit em, ex, br, push, pop, sup;
      em = 0; ex = 0; br = 0; sup = 0;
      if (v) begin
         if (m_brk) begin
            if (b != 8'hE0 && b != 8'hF0) begin em = 1; ex = m_ext; br = 1; end
            m_ext = 0; m_brk = 0;
         end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin em = 1; ex = 1; m_ext = 0; end
         end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) em = 1;
         end
      end
`ifdef PS2_REPEAT_FILTER_EN
      if (em && !ex && !br)
         for (int i = 0; i < 4; i++) if (CODES[8*i +: 8] == b && m_keys[i]) sup = 1;
`endif
      push = em && !sup;
      pop  = rdy && (mq.size() > 0);
      if (push && !(mq.size() < DEPTH || pop)) begin
         m_ovf = 1'b1;
         push  = 0;
      end else if (clr) begin
         m_ovf = 1'b0;
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({ex, br, b});
      if (em && !ex)
         for (int i = 0; i < 4; i++) if (CODES[8*i +: 8] == b) m_keys[i] = !br;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
      rx_valid     = v;
      rx_data      = b;
      ev_ready     = rdy;
      clr_overflow = clr;
      model_cycle(v, b, rdy, clr);
      @(posedge clock);
      #1;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      ev_ready     = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " count"}, 32'(count), 32'(mq.size()));
      chk({tag, " ev_valid"}, 32'(ev_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk({tag, " ev_data"}, 32'(ev_data), 32'(mq[0]));
      chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, " key_down"}, 32'(key_down), 32'(m_keys));
   endtask

   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       rdy;
      int         cnt;
      logic [9:0] head;
      logic [3:0] keys;
   } vec_t;

   vec_t vecs [30];
   logic [7:0] exp5 [8];
   logic [7:0] pool [12];

   initial begin
      vecs[0]  = '{1, 8'h1D, 0, 1, 10'h01D, 4'b0001};
      vecs[1]  = '{1, 8'hF0, 0, 1, 10'h01D, 4'b0001};
      vecs[2]  = '{1, 8'h1D, 0, 2, 10'h01D, 4'b0000};
      vecs[3]  = '{0, 8'h00, 1, 1, 10'h11D, 4'b0000};
      vecs[4]  = '{0, 8'h00, 1, 0, 10'h000, 4'b0000};
      vecs[5]  = '{1, 8'hE0, 0, 0, 10'h000, 4'b0000};
      vecs[6]  = '{1, 8'h75, 0, 1, 10'h275, 4'b0000};
      vecs[7]  = '{1, 8'hFA, 0, 1, 10'h275, 4'b0000};
      vecs[8]  = '{1, 8'hE0, 0, 1, 10'h275, 4'b0000};
      vecs[9]  = '{1, 8'hF0, 0, 1, 10'h275, 4'b0000};
      vecs[10] = '{1, 8'h75, 0, 2, 10'h275, 4'b0000};
      vecs[11] = '{1, 8'hAA, 0, 2, 10'h275, 4'b0000};
      vecs[12] = '{0, 8'h00, 1, 1, 10'h375, 4'b0000};
      vecs[13] = '{0, 8'h00, 1, 0, 10'h000, 4'b0000};
      vecs[14] = '{1, 8'h1C, 0, 1, 10'h01C, 4'b0010};
      vecs[15] = '{1, 8'hE0, 0, 1, 10'h01C, 4'b0010};
      vecs[16] = '{1, 8'h1C, 0, 2, 10'h01C, 4'b0010};
      vecs[17] = '{1, 8'hF0, 0, 2, 10'h01C, 4'b0010};
      vecs[18] = '{1, 8'hE0, 0, 2, 10'h01C, 4'b0010};
      vecs[19] = '{1, 8'h23, 0, 3, 10'h01C, 4'b1010};
      vecs[20] = '{1, 8'hF0, 0, 3, 10'h01C, 4'b1010};
      vecs[21] = '{1, 8'h1C, 0, 4, 10'h01C, 4'b1000};
      vecs[22] = '{0, 8'h00, 1, 3, 10'h21C, 4'b1000};
      vecs[23] = '{0, 8'h00, 1, 2, 10'h023, 4'b1000};
      vecs[24] = '{0, 8'h00, 1, 1, 10'h11C, 4'b1000};
      vecs[25] = '{0, 8'h00, 1, 0, 10'h000, 4'b1000};
      vecs[26] = '{1, 8'hF0, 0, 0, 10'h000, 4'b1000};
      vecs[27] = '{1, 8'h23, 0, 1, 10'h123, 4'b0000};
      vecs[28] = '{0, 8'h00, 1, 0, 10'h000, 4'b0000};
      vecs[29] = '{0, 8'h00, 1, 0, 10'h000, 4'b0000};
      exp5 = '{8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h16};
      pool = '{8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'h00, 8'hFF,
               8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h2D};

      resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ev_ready = 1'b0; clr_overflow = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;

      chk("reset count", 32'(count), 0);
      chk("reset ev_valid", 32'(ev_valid), 0);
      chk("reset overflow", 32'(overflow), 0);
      chk("reset key_down", 32'(key_down), 0);

      for (int i = 0; i < 30; i++) begin
         step(vecs[i].v, vecs[i].b, vecs[i].rdy, 1'b0);
         chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d ev_valid", i), 32'(ev_valid), 32'(vecs[i].cnt != 0));
         if (vecs[i].cnt != 0) chk($sformatf("vec%0d ev_data", i), 32'(ev_data), 32'(vecs[i].head));
         chk($sformatf("vec%0d key_down", i), 32'(key_down), 32'(vecs[i].keys));
         chk($sformatf("vec%0d overflow", i), 32'(overflow), 0);
      end

      // Fill past capacity with no consumer.
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h15 + i), 1'b0, 1'b0);
      chk("full count", 32'(count), 8);
      chk("full overflow", 32'(overflow), 1);
      chk("full head", 32'(ev_data), 32'h015);
      chk("full key_down", 32'(key_down), 32'b0111);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr overflow", 32'(overflow), 0);
      chk("clr count", 32'(count), 8);

      // Push onto a full FIFO in the same cycle as a pop.
      step(1'b1, 8'h16, 1'b1, 1'b0);
      chk("pushpop count", 32'(count), 8);
      chk("pushpop overflow", 32'(overflow), 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d head", i), 32'(ev_data), 32'({2'b00, exp5[i]}));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain count", 32'(count), 0);

      // A drop coinciding with clr_overflow leaves overflow set.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step(1'b1, 8'h40, 1'b0, 1'b1);
      chk("drop vs clr overflow", 32'(overflow), 1);
      chk("drop vs clr count", 32'(count), 8);

      // Reset while an E0 prefix is pending.
      do_reset();
      step(1'b1, 8'hE0, 1'b0, 1'b0);
      resetn = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      resetn = 1'b1;
      chk("midreset count", 32'(count), 0);
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      chk("midreset head", 32'(ev_data), 32'h01C);
      chk("midreset count after", 32'(count), 1);

      // Typematic repeat of a tracked key.
      do_reset();
      step(1'b1, 8'h1D, 1'b0, 1'b0);
      step(1'b1, 8'h1D, 1'b0, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
      chk("repeat count", 32'(count), 1);
`else
      chk("repeat count", 32'(count), 2);
`endif
      chk("repeat key_down", 32'(key_down), 32'b0001);

      // Randomized traffic against the reference model, slow and fast consumer.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic v, rdy, clr;
         logic [7:0] b;
         v   = ($urandom_range(0, 3) != 0);
         b   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
         rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         step(v, b, rdy, clr);
         check_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
Parametrised successor to the single-register "last key received" latch that sits between the PS2_Controller and the game FSM. It parses the raw PS/2 set-2 byte stream into make/break events, handling the E0 (extended) and F0 (break) prefixes. It keeps a live held-down bitmap for a configurable set of game keys. It buffers events in a first-word-fall-through FIFO, so the game FSM consumes every keystroke instead of sampling only the latest byte.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
NUM_KEYS, 4, number of tracked keys in the key_down bitmap.
KEY_CODES, {8'h23,8'h1B,8'h1C,8'h1D}, packed NUM_KEYS*8 codes; slot i is bits [8i+7:8i]. Default slots 0..3 are W, A, S, D (1D, 1C, 1B, 23).

Ports:
clock  input  1  system clock (CLOCK_50)
resetn  input  1  asynchronous active-low reset
rx_data  input  8  byte from PS2_Controller received_data
rx_valid  input  1  one-cycle strobe, received_data_en
ev_data  output  10  head event {ext, brk, code[7:0]}; valid only while ev_valid=1
ev_valid  output  1  FIFO non-empty
ev_ready  input  1  consumer pops the head when ev_valid&ev_ready
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: an event was dropped because the FIFO was full
clr_overflow  input  1  synchronous clear of overflow
key_down  output  NUM_KEYS  1 = tracked key currently held

Behaviour:
- Reset (asynchronous, resetn=0):
  - parser returns to IDLE; FIFO is emptied; pointers are cleared.
  - count=0, ev_valid=0, overflow=0, key_down=0. ev_data is don't-care.
  - Reset mid-sequence discards any pending prefix.
- Parser FSM. States are IDLE, EXT, BRK and EXT_BRK. It advances only on cycles where rx_valid=1.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 00, AA, EE, FA, FE or FF -> ignored, stay in IDLE.
    - any other byte -> emit {0,0,byte}, stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - any other byte -> emit {1,0,byte}, go to IDLE.
  - BRK:
    - E0 or F0 -> protocol error; drop the byte and go to IDLE.
    - any other byte -> emit {0,1,byte}, go to IDLE.
  - EXT_BRK:
    - E0 or F0 -> drop the byte and go to IDLE.
    - any other byte -> emit {1,1,byte}, go to IDLE.
- key_down:
  - Updated on the emit cycle, registered, visible the next cycle.
  - Affected only by events with ext=0.
  - Make sets, and break clears, every slot whose KEY_CODES entry equals the code.
  - key_down is independent of FIFO full and of the repeat filter.
- FIFO:
  - An emit is a push. A push is written on the same edge as the emit and appears at the head one cycle after the rx_valid of the final byte when the FIFO was empty.
  - Pop: ev_valid&ev_ready advances the head on the clock edge.
  - A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the push is dropped, overflow is set to 1, and count and contents are unchanged.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Overflow: clr_overflow clears it. If clr_overflow coincides with a new drop, the drop wins and overflow stays 1.

Optional Feature:
Macro: PS2_REPEAT_FILTER_EN.
- Defined: a make event (ext=0) whose code matches a slot already set in key_down is not pushed; this suppresses typematic repeats. Non-tracked codes and all breaks are always pushed.
- Undefined: every make is pushed, including repeats.
- key_down behaves identically in both builds.

Test Plan:
1. Reset, then rx 1D -> next cycle ev_valid=1, ev_data=0x01D, count=1, key_down=4'b0001.
2. After (1): rx F0, 1D; pop both -> second event 0x11D; key_down=0; count=0 after pops.
3. rx E0, 75, then E0, F0, 75 -> events 0x275 then 0x375; key_down unchanged; FA and AA bytes interleaved in IDLE produce no events.
4. DEPTH=8, ev_ready=0, send 9 makes 0x15..0x1D -> count=8, overflow=1, head=0x015, 0x1D not stored (key_down[0] still 1). Then pulse clr_overflow -> overflow=0.
5. FIFO full, push (rx 0x16) in the same cycle as a pop -> count stays 8, overflow stays 0, tail entry=0x016.
6. Reset mid-sequence: rx E0, assert resetn=0 for 1 cycle, release, rx 1C -> event 0x01C (not 0x21C).
   - Filter build: rx 1D, 1D -> one event only.
   - Non-filter build: rx 1D, 1D -> two events.
